// File: rtl/wl_rom_arb.sv
// ---------------------------------------------------------------------------
// wl_rom_arb
//   Round-robin arbiter sharing one single-port lookup ROM between NREQ
//   requesters. At most one read is granted per cycle; the ROM en/addr pins
//   are driven from registers and each ROM result is steered back to the
//   requester that issued it, two cycles after the handshake edge.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   arb_en     1 = arbitration enabled, 0 = no new grants
//   req_valid  per-requester read request
//   req_addr   requester i address at [i*AW +: AW]
//   req_ready  one-hot grant (combinational)
//   rsp_valid  one-hot, 1-cycle pulse marking the owner of rsp_data
//   rsp_data   ROM result, shared by all requesters
//   rom_en     to ROM en
//   rom_addr   to ROM addr
//   rom_dout   from ROM dout (registered inside the ROM, 1-cycle read)
//   busy       1 while any read is in flight
// ---------------------------------------------------------------------------
module wl_rom_arb #(
  parameter int DW   = 8,
  parameter int AW   = 8,
  parameter int NREQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arb_en,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               rom_en,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_dout,
  output logic               busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] cand;
  logic          grant_hit;
  logic [IW-1:0] grant_id;
  logic [AW-1:0] grant_addr;

  // Per-read pipeline: tag0 = ISSUED (ROM address presented),
  // tag1 = ROMRD (ROM output register loaded, response this cycle).
  logic          tag0_v;
  logic [IW-1:0] tag0_id;
  logic          tag1_v;
  logic [IW-1:0] tag1_id;

  // Scan from ptr upward, wrapping; the first asserted request wins.
  always_comb begin
    grant_hit = 1'b0;
    grant_id  = '0;
    cand      = '0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (arb_en && !grant_hit && req_valid[cand]) begin
        grant_hit = 1'b1;
        grant_id  = cand;
      end
    end
    if (grant_hit) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    grant_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IW'(i)) grant_addr = req_addr[i*AW +: AW];
    end
  end

  assign ptr_nxt = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      tag0_v   <= 1'b0;
      tag0_id  <= '0;
      tag1_v   <= 1'b0;
      tag1_id  <= '0;
    end else begin
      rom_en  <= grant_hit;
      tag0_v  <= grant_hit;
      tag1_v  <= tag0_v;
      tag1_id <= tag0_id;
      if (grant_hit) begin
        rom_addr <= grant_addr;
        tag0_id  <= grant_id;
        ptr      <= ptr_nxt;
      end
    end
  end

  // Decode of the registered tag1 stage, aligned with the ROM output register.
  always_comb begin
    rsp_valid = '0;
    if (tag1_v) rsp_valid[tag1_id] = 1'b1;
  end

  assign rsp_data = rom_dout;
  assign busy     = rom_en | tag0_v | tag1_v;

endmodule

// File: tb/tb_wl_rom_arb.sv
module tb_wl_rom_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arb_en;
  logic [3:0]  req_valid;
  logic [31:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_dout;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  wl_rom_arb #(.DW(8), .AW(8), .NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_en    (arb_en),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // ROM model: registered read, rom[a] = a ^ 8'hA5
  initial rom_dout = 8'h00;
  always @(posedge clk) if (rom_en) rom_dout <= rom_addr ^ 8'hA5;

  // ---------------- reference model ----------------
  typedef struct {
    bit         v;
    int         id;
    logic [7:0] addr;
  } hs_t;

  int  mptr;
  hs_t h1, h2;       // handshakes one and two cycles ago
  int  g;            // grant predicted for the current cycle (-1 = none)

  function automatic int mgrant(logic en, logic [3:0] v, int p);
    if (!en) return -1;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (p + k) % 4;
      if (((v >> j) & 4'd1) != 4'd0) return j;
    end
    return -1;
  endfunction

  task automatic model_clear();
    mptr = 0;
    h1.v = 0; h1.id = 0; h1.addr = 8'h00;
    h2.v = 0; h2.id = 0; h2.addr = 8'h00;
    g = -1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model on the falling edge.
  task automatic sample();
    logic [3:0] erdy, erv;
    @(negedge clk);
    g    = mgrant(arb_en, req_valid, mptr);
    erdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    erv  = h2.v ? 4'(1 << h2.id) : 4'b0;
    chk("m_ready", 32'(req_ready), 32'(erdy));
    chk("m_rsp_valid", 32'(rsp_valid), 32'(erv));
    if (h2.v) chk("m_rsp_data", 32'(rsp_data), 32'(h2.addr ^ 8'hA5));
    chk("m_busy", 32'(busy), 32'(h1.v | h2.v));
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      h2 = h1;
      h1.v = (g >= 0);
      if (g >= 0) begin
        h1.id   = g;
        h1.addr = 8'(req_addr >> (8 * g));
        mptr    = (g + 1) % 4;
      end
    end
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        en;
    logic [3:0]  v;
    logic [31:0] addr;
    logic [3:0]  rdy;
    logic [3:0]  rv;
    logic [7:0]  rd;
    logic        busy;
  } vec_t;

  vec_t vec [26];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // T2 contention from reset, addrs 0..3
    vec[0]  = '{1'b1, 4'hF, 32'h03020100, 4'b0001, 4'b0000, 8'h00, 1'b0};
    vec[1]  = '{1'b1, 4'hF, 32'h03020100, 4'b0010, 4'b0000, 8'h00, 1'b1};
    vec[2]  = '{1'b1, 4'hF, 32'h03020100, 4'b0100, 4'b0001, 8'hA5, 1'b1};
    vec[3]  = '{1'b1, 4'hF, 32'h03020100, 4'b1000, 4'b0010, 8'hA4, 1'b1};
    vec[4]  = '{1'b1, 4'hF, 32'h03020100, 4'b0001, 4'b0100, 8'hA7, 1'b1};
    vec[5]  = '{1'b1, 4'hF, 32'h03020100, 4'b0010, 4'b1000, 8'hA6, 1'b1};
    vec[6]  = '{1'b1, 4'h0, 32'h03020100, 4'b0000, 4'b0001, 8'hA5, 1'b1};
    vec[7]  = '{1'b1, 4'h0, 32'h03020100, 4'b0000, 4'b0010, 8'hA4, 1'b1};
    vec[8]  = '{1'b1, 4'h0, 32'h03020100, 4'b0000, 4'b0000, 8'h00, 1'b0};
    // T1 single request from req 2, addr 8'h10
    vec[9]  = '{1'b1, 4'h4, 32'h00100000, 4'b0100, 4'b0000, 8'h00, 1'b0};
    vec[10] = '{1'b1, 4'h0, 32'h00100000, 4'b0000, 4'b0000, 8'h00, 1'b1};
    vec[11] = '{1'b1, 4'h0, 32'h00100000, 4'b0000, 4'b0100, 8'hB5, 1'b1};
    vec[12] = '{1'b1, 4'h0, 32'h00100000, 4'b0000, 4'b0000, 8'h00, 1'b0};
    // T3 wrap: ptr=3, req 0 (addr 40) and req 3 (addr 33)
    vec[13] = '{1'b1, 4'h9, 32'h33000040, 4'b1000, 4'b0000, 8'h00, 1'b0};
    vec[14] = '{1'b1, 4'h9, 32'h33000040, 4'b0001, 4'b0000, 8'h00, 1'b1};
    vec[15] = '{1'b1, 4'h0, 32'h33000040, 4'b0000, 4'b1000, 8'h96, 1'b1};
    vec[16] = '{1'b1, 4'h0, 32'h33000040, 4'b0000, 4'b0001, 8'hE5, 1'b1};
    vec[17] = '{1'b1, 4'h0, 32'h33000040, 4'b0000, 4'b0000, 8'h00, 1'b0};
    // ptr must now be 1: req 1 beats req 0
    vec[18] = '{1'b1, 4'h3, 32'h00000000, 4'b0010, 4'b0000, 8'h00, 1'b0};
    vec[19] = '{1'b1, 4'h0, 32'h00000000, 4'b0000, 4'b0000, 8'h00, 1'b1};
    vec[20] = '{1'b1, 4'h0, 32'h00000000, 4'b0000, 4'b0010, 8'hA5, 1'b1};
    vec[21] = '{1'b1, 4'h0, 32'h00000000, 4'b0000, 4'b0000, 8'h00, 1'b0};
    // T5 arb_en dropped after grant to req 0, addr FF
    vec[22] = '{1'b1, 4'h1, 32'h000000FF, 4'b0001, 4'b0000, 8'h00, 1'b0};
    vec[23] = '{1'b0, 4'h1, 32'h000000FF, 4'b0000, 4'b0000, 8'h00, 1'b1};
    vec[24] = '{1'b0, 4'h1, 32'h000000FF, 4'b0000, 4'b0001, 8'h5A, 1'b1};
    vec[25] = '{1'b0, 4'h1, 32'h000000FF, 4'b0000, 4'b0000, 8'h00, 1'b0};

    rst_n = 1'b0; arb_en = 1'b0; req_valid = 4'h0; req_addr = 32'h0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rom_en", 32'(rom_en), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      arb_en = vec[i].en; req_valid = vec[i].v; req_addr = vec[i].addr;
      sample();
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vec[i].rdy));
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vec[i].rv));
      if (vec[i].rv != 4'b0)
        chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(vec[i].rd));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vec[i].busy));
      advance();
    end

    // T4 streaming: req 1 alone, addr 0..9, then drain
    arb_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req_valid = (i < 10) ? 4'b0010 : 4'b0000;
      req_addr  = 32'(i) << 8;
      sample();
      chk("t4_ready", 32'(req_ready), (i < 10) ? 32'h2 : 32'h0);
      if (i >= 2) begin
        chk("t4_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("t4_rsp_data", 32'(rsp_data), 32'(8'(i - 2) ^ 8'hA5));
      end
      advance();
    end
    req_valid = 4'h0;
    sample(); advance();
    sample(); advance();

    // T6 reset one cycle after a handshake
    req_valid = 4'b1000; req_addr = 32'h21000000;
    sample();
    chk("t6_hs", 32'(req_ready), 32'h8);
    advance();
    req_valid = 4'h0;
    rst_n = 1'b0;
    model_clear();
    sample();
    chk("t6_busy_rst", 32'(busy), 32'd0);
    advance();
    sample();
    chk("t6_rsp_rst", 32'(rsp_valid), 32'd0);
    advance();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      advance();
    end
    req_valid = 4'hF; req_addr = 32'h44332211;
    sample();
    chk("t6_ptr0", 32'(req_ready), 32'h1);
    advance();
    req_valid = 4'h0;
    sample(); advance();
    sample();
    chk("t6_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t6_rsp_data", 32'(rsp_data), 32'(8'h11 ^ 8'hA5));
    advance();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      arb_en    = ($urandom_range(0, 7) != 0);
      req_valid = 4'($urandom);
      req_addr  = $urandom;
      sample();
      advance();
    end
    arb_en = 1'b0; req_valid = 4'h0;
    repeat (3) begin sample(); advance(); end
    sample();
    chk("final_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
